deskew_reset_sequencer: RTL and testbench

DESKEW_RESET_SEQUENCER -- requirements
Module: deskew_reset_sequencer

---
 rtl/deskew_pkg.sv | 20 ++
 rtl/sync_ff.sv | 27 ++
 rtl/deskew_reset_sequencer.sv | 133 +++++++++++++
 tb/tb_deskew_reset_sequencer.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/deskew_pkg.sv
// Shared definitions for the deskew reset sequencer and related blocks.
//   - CNT_W     : width of the sequencer cycle counter
//   - state_t   : FSM state encoding with the four sequencer states
//   - sat_inc8  : 8-bit saturating increment used by the loss counter
package deskew_pkg;

    localparam int CNT_W = 16;

    typedef logic [1:0] state_t;

    localparam state_t ST_WAIT_LOCK = 2'd0;
    localparam state_t ST_STABLE    = 2'd1;
    localparam state_t ST_HOLD      = 2'd2;
    localparam state_t ST_RUN       = 2'd3;

    function automatic logic [7:0] sat_inc8(input logic [7:0] value);
        return (value == 8'hFF) ? value : value + 8'd1;
    endfunction

endpackage

// File: rtl/sync_ff.sv
// Multi-flop synchronizer for a single asynchronous bit.
//   clk   : destination clock
//   rst_n : asynchronous active-low reset, clears every stage to 0
//   d     : asynchronous input
//   q     : synchronized output, DEPTH clk edges behind d
module sync_ff #(
    parameter int DEPTH = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic [DEPTH-1:0] stages;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stages <= '0;
        end else begin
            stages <= {stages[DEPTH-2:0], d};
        end
    end

    assign q = stages[DEPTH-1];

endmodule

// File: rtl/deskew_reset_sequencer.sv
// Reset sequencer for logic clocked by a deskewed (MMCM/DCM) clock.
// Waits for LOCKED to be stable, holds reset for a fixed time, then
// releases it. Lock losses seen while running are flagged and counted.
//   clk_i        : deskewed clock
//   rst_n_i      : asynchronous active-low reset
//   locked_i     : LOCKED flag from the deskew primitive (asynchronous)
//   clear_i      : synchronous clear of lock_lost_o / loss_count_o
//   rst_o        : active-high reset for the clk_i domain
//   ready_o      : high only while running
//   lock_lost_o  : sticky lock-loss flag
//   loss_count_o : saturating count of lock losses while running
//
// state      | meaning
// WAIT_LOCK  | waiting for synchronized lock
// STABLE     | counting consecutive lock cycles
// HOLD       | lock deemed stable, reset still held
// RUN        | reset released, ready asserted
module deskew_reset_sequencer
    import deskew_pkg::*;
#(
    parameter int SYNC_STAGES   = 2,
    parameter int STABLE_CYCLES = 256,
    parameter int HOLD_CYCLES   = 1024
) (
    input  logic       clk_i,
    input  logic       rst_n_i,
    input  logic       locked_i,
    input  logic       clear_i,
    output logic       rst_o,
    output logic       ready_o,
    output logic       lock_lost_o,
    output logic [7:0] loss_count_o
);

    localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(HOLD_CYCLES - 1);

    logic             lock_s;
    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic             loss_event;

    sync_ff #(
        .DEPTH (SYNC_STAGES)
    ) u_sync_lock (
        .clk   (clk_i),
        .rst_n (rst_n_i),
        .d     (locked_i),
        .q     (lock_s)
    );

    // The counter is cleared on every transition, so it never needs to wrap.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            ST_WAIT_LOCK: begin
                cnt_nxt = '0;
                if (lock_s) begin
                    state_nxt = ST_STABLE;
                end
            end
            ST_STABLE: begin
                if (!lock_s) begin
                    state_nxt = ST_WAIT_LOCK;
                    cnt_nxt   = '0;
                end else if (cnt == STABLE_LAST) begin
                    state_nxt = ST_HOLD;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            ST_HOLD: begin
                if (!lock_s) begin
                    state_nxt = ST_WAIT_LOCK;
                    cnt_nxt   = '0;
                end else if (cnt == HOLD_LAST) begin
                    state_nxt = ST_RUN;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            ST_RUN: begin
                cnt_nxt = '0;
                if (!lock_s) begin
                    state_nxt = ST_WAIT_LOCK;
                end
            end
            default: begin
                state_nxt = ST_WAIT_LOCK;
                cnt_nxt   = '0;
            end
        endcase
    end

    // Only a drop out of RUN is a lock loss worth recording.
    assign loss_event = (state == ST_RUN) && !lock_s;

    // Outputs are decoded from the next state so they move on the same
    // edge as the state register.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state   <= ST_WAIT_LOCK;
            cnt     <= '0;
            rst_o   <= 1'b1;
            ready_o <= 1'b0;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            rst_o   <= (state_nxt != ST_RUN);
            ready_o <= (state_nxt == ST_RUN);
        end
    end

    // Clear wins over a coincident loss; that loss is dropped.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            lock_lost_o  <= 1'b0;
            loss_count_o <= 8'd0;
        end else if (clear_i) begin
            lock_lost_o  <= 1'b0;
            loss_count_o <= 8'd0;
        end else if (loss_event) begin
            lock_lost_o  <= 1'b1;
            loss_count_o <= sat_inc8(loss_count_o);
        end
    end

endmodule

// File: tb/tb_deskew_reset_sequencer.sv
`timescale 1ns/1ps
module tb_deskew_reset_sequencer;

    logic       clk_i = 1'b0;
    logic       rst_n_i;
    logic       locked_i;
    logic       clear_i;
    logic       rst_o;
    logic       ready_o;
    logic       lock_lost_o;
    logic [7:0] loss_count_o;

    always #5 clk_i = ~clk_i;

    deskew_reset_sequencer #(
        .SYNC_STAGES   (2),
        .STABLE_CYCLES (4),
        .HOLD_CYCLES   (8)
    ) dut (
        .clk_i        (clk_i),
        .rst_n_i      (rst_n_i),
        .locked_i     (locked_i),
        .clear_i      (clear_i),
        .rst_o        (rst_o),
        .ready_o      (ready_o),
        .lock_lost_o  (lock_lost_o),
        .loss_count_o (loss_count_o)
    );

    typedef struct {
        string      tag;
        logic       rst;
        logic       ready;
        logic       lost;
        logic [7:0] cnt;
    } exp_t;

    exp_t       sb[$];
    int         n_checks = 0;
    int         n_pass   = 0;
    logic       model_lost;
    logic [7:0] model_cnt;

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk_i);
            #1;
        end
    endtask

    task automatic push_exp(input string tag, input logic r, input logic rd);
        exp_t e;
        e.tag   = tag;
        e.rst   = r;
        e.ready = rd;
        e.lost  = model_lost;
        e.cnt   = model_cnt;
        sb.push_back(e);
    endtask

    task automatic check_out();
        exp_t       e;
        logic [10:0] got;
        logic [10:0] want;
        n_checks++;
        if (sb.size() == 0) begin
            $error("FAIL scoreboard_empty: observed no expectation, expected one queued");
            return;
        end
        e    = sb.pop_front();
        got  = {rst_o, ready_o, lock_lost_o, loss_count_o};
        want = {e.rst, e.ready, e.lost, e.cnt};
        assert (got === want) n_pass++;
        else $error("FAIL %s: observed rst=%b ready=%b lost=%b count=%0d, expected rst=%b ready=%b lost=%b count=%0d",
                    e.tag, rst_o, ready_o, lock_lost_o, loss_count_o, e.rst, e.ready, e.lost, e.cnt);
    endtask

    task automatic record_loss();
        model_lost = 1'b1;
        model_cnt  = (model_cnt == 8'd255) ? 8'd255 : model_cnt + 8'd1;
    endtask

    initial begin
        rst_n_i    = 1'b1;
        locked_i   = 1'b0;
        clear_i    = 1'b0;
        model_lost = 1'b0;
        model_cnt  = 8'd0;

        // Asynchronous reset before any clock edge
        #1 rst_n_i = 1'b0;
        #1;
        push_exp("reset_async", 1'b1, 1'b0);
        check_out();
        tick(2);
        push_exp("reset_held", 1'b1, 1'b0);
        check_out();

        // Power-up: locked sampled high at edge 1, rst_o falls at edge 15
        rst_n_i  = 1'b1;
        locked_i = 1'b1;
        push_exp("powerup_e14", 1'b1, 1'b0);
        tick(14);
        check_out();
        push_exp("powerup_e15", 1'b0, 1'b1);
        tick(1);
        check_out();

        // Loss in RUN: synchronizer sees drop at edge 1, outputs react at edge 3
        locked_i = 1'b0;
        push_exp("run_loss_e2", 1'b0, 1'b1);
        tick(2);
        check_out();
        record_loss();
        push_exp("run_loss_e3", 1'b1, 1'b0);
        tick(1);
        check_out();
        tick(2);
        locked_i = 1'b1;
        push_exp("relock_e14", 1'b1, 1'b0);
        tick(14);
        check_out();
        push_exp("relock_e15", 1'b0, 1'b1);
        tick(1);
        check_out();

        // Second loss, then a glitch after two STABLE cycles restarts the sequence
        locked_i = 1'b0;
        tick(2);
        record_loss();
        push_exp("loss2", 1'b1, 1'b0);
        tick(1);
        check_out();
        tick(2);
        locked_i = 1'b1;
        tick(3);
        locked_i = 1'b0;
        tick(3);
        locked_i = 1'b1;
        push_exp("glitch_no_run_e15", 1'b1, 1'b0);
        tick(9);
        check_out();
        push_exp("glitch_e20", 1'b1, 1'b0);
        tick(5);
        check_out();
        push_exp("glitch_e21", 1'b0, 1'b1);
        tick(1);
        check_out();

        // Saturation: 258 more losses for 260 in total
        for (int i = 0; i < 258; i++) begin
            locked_i = 1'b0;
            record_loss();
            push_exp("sat_loss", 1'b1, 1'b0);
            tick(3);
            check_out();
            locked_i = 1'b1;
            tick(15);
        end
        push_exp("sat_run", 1'b0, 1'b1);
        check_out();

        // Clear pulse
        clear_i    = 1'b1;
        model_lost = 1'b0;
        model_cnt  = 8'd0;
        push_exp("clear", 1'b0, 1'b1);
        tick(1);
        check_out();
        clear_i = 1'b0;

        // Clear coincident with a loss: the loss is not recorded
        locked_i = 1'b0;
        tick(2);
        clear_i = 1'b1;
        push_exp("clear_vs_loss", 1'b1, 1'b0);
        tick(1);
        check_out();
        clear_i = 1'b0;

        // Build up a nonzero count, then reset asynchronously mid-HOLD
        locked_i = 1'b1;
        tick(15);
        locked_i = 1'b0;
        record_loss();
        push_exp("pre_reset_loss", 1'b1, 1'b0);
        tick(3);
        check_out();
        locked_i = 1'b1;
        tick(9);
        #2 rst_n_i = 1'b0;
        #1;
        model_lost = 1'b0;
        model_cnt  = 8'd0;
        push_exp("async_rst_hold", 1'b1, 1'b0);
        check_out();
        #2 rst_n_i = 1'b1;
        push_exp("restart_e14", 1'b1, 1'b0);
        tick(14);
        check_out();
        push_exp("restart_e15", 1'b0, 1'b1);
        tick(1);
        check_out();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
